// File: rtl/sync_pkg.sv
// Shared types for the synchronous handshake layer.
package sync_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StAckd,
    StRtz
  } fork_state_e;

endpackage

// File: rtl/fork_watchdog.sv
// Saturating per-state cycle counter with a sticky timeout flag.
module fork_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic state_chg_i,
  input  logic count_en_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_err, w_err_next;

  always_comb begin
    w_cnt_next = r_cnt;
    if (state_chg_i) begin
      w_cnt_next = '0;
    end else if (count_en_i && (r_cnt != MaxCnt)) begin
      w_cnt_next = r_cnt + 1'b1;
    end
    w_err_next = r_err | (w_cnt_next == MaxCnt);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_err <= w_err_next;
    end
  end

  assign timeout_o = r_err;

endmodule

// File: rtl/fork_n_sync.sv
// Clocked N-way fork for 4-phase req/ack channels with C-element style ack join,
// branch masking, protocol-violation flag and optional watchdog.
module fork_n_sync
  import sync_pkg::*;
#(
  parameter int unsigned N_OUT       = 2,
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter int unsigned CNT_W       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_in_i,
  output logic             ack_in_o,
  input  logic [N_OUT-1:0] en_i,
  output logic [N_OUT-1:0] req_out_o,
  input  logic [N_OUT-1:0] ack_out_i,
  output logic             busy_o,
  output logic             err_timeout_o,
  output logic             err_proto_o
);

  fork_state_e      r_state, w_state_next;
  logic [N_OUT-1:0] r_mask, w_mask_next;
  logic [N_OUT-1:0] r_done, w_done_next;
  logic [N_OUT-1:0] r_req_out, w_req_out_next;
  logic             r_ack_in, w_ack_in_next;
  logic             r_err_proto, w_err_proto_next;

  logic [N_OUT-1:0] w_capture;
  logic [N_OUT-1:0] w_done_set;
  logic             w_all_done;
  logic             w_busy;
  logic             w_violation;

  // FWD waits for each masked ack high, RTZ for each masked ack low.
  for (genvar k = 0; k < N_OUT; k++) begin : g_branch
    always_comb begin
      w_capture[k] = 1'b0;
      if (r_mask[k]) begin
        if (r_state == StFwd) w_capture[k] = ack_out_i[k];
        else if (r_state == StRtz) w_capture[k] = ~ack_out_i[k];
      end
    end
    assign w_done_set[k] = r_done[k] | w_capture[k];
  end

  assign w_all_done = (w_done_set == r_mask);
  assign w_busy     = (r_state != StIdle);

  assign w_violation = ((r_state == StFwd) && !req_in_i)
                     || (w_busy && |(ack_out_i & ~r_mask))
                     || ((r_state == StIdle) && |ack_out_i);

  always_comb begin
    w_state_next     = r_state;
    w_mask_next      = r_mask;
    w_done_next      = r_done;
    w_req_out_next   = r_req_out;
    w_ack_in_next    = r_ack_in;
    w_err_proto_next = r_err_proto | w_violation;
    unique case (r_state)
      StIdle: begin
        if (req_in_i && !r_ack_in) begin
          w_mask_next = en_i;
          w_done_next = '0;
          if (en_i == '0) begin
            w_ack_in_next = 1'b1;
            w_state_next  = StAckd;
          end else begin
            w_req_out_next = en_i;
            w_state_next   = StFwd;
          end
        end
      end
      StFwd: begin
        w_done_next = w_done_set;
        if (w_all_done) begin
          w_ack_in_next = 1'b1;
          w_state_next  = StAckd;
        end
      end
      StAckd: begin
        if (!req_in_i) begin
          w_req_out_next = '0;
          w_done_next    = '0;
          w_state_next   = StRtz;
        end
      end
      StRtz: begin
        w_done_next = w_done_set;
        if (w_all_done) begin
          w_ack_in_next = 1'b0;
          w_state_next  = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_mask      <= '0;
      r_done      <= '0;
      r_req_out   <= '0;
      r_ack_in    <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mask      <= w_mask_next;
      r_done      <= w_done_next;
      r_req_out   <= w_req_out_next;
      r_ack_in    <= w_ack_in_next;
      r_err_proto <= w_err_proto_next;
    end
  end

  if (TIMEOUT_CYC > 0) begin : g_wdog
    logic w_state_chg;
    logic w_count_en;
    assign w_state_chg = (w_state_next != r_state);
    assign w_count_en  = (r_state == StFwd) || (r_state == StRtz);

    fork_watchdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .CNT_W      (CNT_W)
    ) u_wdog (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .state_chg_i(w_state_chg),
      .count_en_i (w_count_en),
      .timeout_o  (err_timeout_o)
    );
  end else begin : g_no_wdog
    assign err_timeout_o = 1'b0;
  end

  assign ack_in_o    = r_ack_in;
  assign req_out_o   = r_req_out;
  assign busy_o      = w_busy;
  assign err_proto_o = r_err_proto;

endmodule

// File: tb/tb_fork_n_sync.sv
// Directed bench: a 3-branch fork without watchdog and a 2-branch fork with a 4-cycle watchdog.
module tb_fork_n_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Instance A: N_OUT=3, watchdog disabled
  logic       a_rst_n, a_req, a_ack_in, a_busy, a_err_to, a_err_pr;
  logic [2:0] a_en, a_req_out, a_ack;

  // Instance B: N_OUT=2, TIMEOUT_CYC=4
  logic       b_rst_n, b_req, b_ack_in, b_busy, b_err_to, b_err_pr;
  logic [1:0] b_en, b_req_out, b_ack;

  fork_n_sync #(.N_OUT(3), .TIMEOUT_CYC(0)) dut_a (
    .clk_i        (clk),
    .rst_ni       (a_rst_n),
    .req_in_i     (a_req),
    .ack_in_o     (a_ack_in),
    .en_i         (a_en),
    .req_out_o    (a_req_out),
    .ack_out_i    (a_ack),
    .busy_o       (a_busy),
    .err_timeout_o(a_err_to),
    .err_proto_o  (a_err_pr)
  );

  fork_n_sync #(.N_OUT(2), .TIMEOUT_CYC(4)) dut_b (
    .clk_i        (clk),
    .rst_ni       (b_rst_n),
    .req_in_i     (b_req),
    .ack_in_o     (b_ack_in),
    .en_i         (b_en),
    .req_out_o    (b_req_out),
    .ack_out_i    (b_ack),
    .busy_o       (b_busy),
    .err_timeout_o(b_err_to),
    .err_proto_o  (b_err_pr)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_req = 1'b0; a_en = '0; a_ack = '0;
    b_req = 1'b0; b_en = '0; b_ack = '0;
    tick(); tick();
    vecs++; if ({a_req_out, a_ack_in, a_busy, a_err_to, a_err_pr} !== 7'b0) begin
      errs++; $display("FAIL reset_a: got %b want %b",
                       {a_req_out, a_ack_in, a_busy, a_err_to, a_err_pr}, 7'b0); end
    vecs++; if ({b_req_out, b_ack_in, b_busy, b_err_to, b_err_pr} !== 6'b0) begin
      errs++; $display("FAIL reset_b: got %b want %b",
                       {b_req_out, b_ack_in, b_busy, b_err_to, b_err_pr}, 6'b0); end
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    tick();
  endtask

  // Acks on branches 1,0,2 at cycles +2,+4,+5; ack_in rises at +6.
  task automatic test_full_fork();
    a_en = 3'b111; a_req = 1'b1;
    tick();
    vecs++; if (a_req_out !== 3'b111) begin errs++;
      $display("FAIL t1_req_out: got %b want %b", a_req_out, 3'b111); end
    vecs++; if (a_busy !== 1'b1) begin errs++;
      $display("FAIL t1_busy: got %b want 1", a_busy); end
    tick();
    a_ack = 3'b010; tick();
    tick();
    a_ack = 3'b011; tick();
    vecs++; if (a_ack_in !== 1'b0) begin errs++;
      $display("FAIL t1_ack_early: got %b want 0", a_ack_in); end
    a_ack = 3'b111; tick();
    vecs++; if (a_ack_in !== 1'b1) begin errs++;
      $display("FAIL t1_ack_in: got %b want 1", a_ack_in); end
    a_req = 1'b0; tick();
    vecs++; if ({a_req_out, a_ack_in} !== 4'b0001) begin errs++;
      $display("FAIL t1_rtz_enter: got %b want %b", {a_req_out, a_ack_in}, 4'b0001); end
    a_ack = 3'b000; tick();
    vecs++; if ({a_ack_in, a_busy, a_err_to, a_err_pr} !== 4'b0) begin errs++;
      $display("FAIL t1_done: got %b want %b", {a_ack_in, a_busy, a_err_to, a_err_pr}, 4'b0); end
  endtask

  task automatic test_empty_mask();
    a_en = 3'b000; a_req = 1'b1;
    tick();
    vecs++; if ({a_ack_in, a_req_out} !== 4'b1000) begin errs++;
      $display("FAIL t3_ack_rise: got %b want %b", {a_ack_in, a_req_out}, 4'b1000); end
    a_req = 1'b0; tick(); tick();
    vecs++; if ({a_ack_in, a_req_out, a_busy} !== 5'b0) begin errs++;
      $display("FAIL t3_ack_fall: got %b want %b", {a_ack_in, a_req_out, a_busy}, 5'b0); end
  endtask

  // Branches 0 and 1 ack together, branch 1 drops before branch 2 arrives.
  task automatic test_sticky_done();
    a_en = 3'b111; a_req = 1'b1;
    tick();
    a_ack = 3'b011; tick();
    a_ack = 3'b001; tick();
    vecs++; if (a_ack_in !== 1'b0) begin errs++;
      $display("FAIL t6_ack_early: got %b want 0", a_ack_in); end
    a_ack = 3'b101; tick();
    vecs++; if (a_ack_in !== 1'b1) begin errs++;
      $display("FAIL t6_ack_in: got %b want 1", a_ack_in); end
    a_req = 1'b0; tick();
    a_ack = 3'b000; tick();
    vecs++; if ({a_ack_in, a_busy, a_err_pr} !== 3'b0) begin errs++;
      $display("FAIL t6_done: got %b want %b", {a_ack_in, a_busy, a_err_pr}, 3'b0); end
  endtask

  // Leaves dut_a in ACKD for the reset test.
  task automatic test_masked_branch();
    a_en = 3'b101; a_req = 1'b1;
    tick();
    vecs++; if (a_req_out !== 3'b101) begin errs++;
      $display("FAIL t2_req_out: got %b want %b", a_req_out, 3'b101); end
    a_ack = 3'b010; tick();
    vecs++; if ({a_err_pr, a_ack_in} !== 2'b10) begin errs++;
      $display("FAIL t2_proto: got %b want %b", {a_err_pr, a_ack_in}, 2'b10); end
    a_ack = 3'b001; tick();
    vecs++; if (a_ack_in !== 1'b0) begin errs++;
      $display("FAIL t2_ack_early: got %b want 0", a_ack_in); end
    a_ack = 3'b100; tick();
    vecs++; if ({a_ack_in, a_req_out} !== 4'b1101) begin errs++;
      $display("FAIL t2_ack_in: got %b want %b", {a_ack_in, a_req_out}, 4'b1101); end
  endtask

  task automatic test_reset_mid();
    a_rst_n = 1'b0; a_req = 1'b0; a_ack = '0;
    tick();
    vecs++; if ({a_req_out, a_ack_in, a_busy, a_err_to, a_err_pr} !== 7'b0) begin errs++;
      $display("FAIL t5_reset: got %b want %b",
               {a_req_out, a_ack_in, a_busy, a_err_to, a_err_pr}, 7'b0); end
    a_rst_n = 1'b1; a_en = 3'b011; a_req = 1'b1;
    tick();
    vecs++; if (a_req_out !== 3'b011) begin errs++;
      $display("FAIL t5_req_out: got %b want %b", a_req_out, 3'b011); end
    a_ack = 3'b011; tick();
    vecs++; if (a_ack_in !== 1'b1) begin errs++;
      $display("FAIL t5_ack_in: got %b want 1", a_ack_in); end
    a_req = 1'b0; tick();
    a_ack = 3'b000; tick();
    vecs++; if ({a_ack_in, a_busy, a_err_pr, a_req_out} !== 6'b0) begin errs++;
      $display("FAIL t5_done: got %b want %b", {a_ack_in, a_busy, a_err_pr, a_req_out}, 6'b0);
    end
  endtask

  // Branch 0 withheld: counter reaches 4 at the 4th FWD edge.
  task automatic test_timeout();
    b_en = 2'b11; b_req = 1'b1;
    tick();
    b_ack = 2'b10;
    tick(); tick(); tick();
    vecs++; if (b_err_to !== 1'b0) begin errs++;
      $display("FAIL t4_no_timeout: got %b want 0", b_err_to); end
    tick();
    vecs++; if ({b_err_to, b_ack_in} !== 2'b10) begin errs++;
      $display("FAIL t4_timeout: got %b want %b", {b_err_to, b_ack_in}, 2'b10); end
    b_ack = 2'b11; tick();
    vecs++; if ({b_ack_in, b_err_to} !== 2'b11) begin errs++;
      $display("FAIL t4_late_ack: got %b want %b", {b_ack_in, b_err_to}, 2'b11); end
    b_req = 1'b0; tick();
    b_ack = 2'b00; tick();
    vecs++; if ({b_ack_in, b_busy, b_err_to, b_err_pr} !== 4'b0010) begin errs++;
      $display("FAIL t4_done: got %b want %b", {b_ack_in, b_busy, b_err_to, b_err_pr}, 4'b0010);
    end
  endtask

  initial begin
    test_reset();
    test_full_fork();
    test_empty_mask();
    test_sticky_done();
    test_masked_branch();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
